line_raster: RTL and testbench
==============================

# line_raster

Parametrised Bresenham line rasteriser for the graphics pipeline. It is the successor to the fixed 10-bit line drawer and sits between the command decoder and the framebuffer writer. It accepts one line command per handshake and emits one pixel per output handshake. Over the fixed drawer it adds:
- configurable coordinate and colour widths;
- endpoint-order-preserving traversal in all eight octants;
- screen clipping;
- dash and two-colour pattern modes;
- a last-pixel flag and a done pulse.

## Interface
Parameters:
- COORD_W, 10, coordinate width (unsigned)
- COLOR_W, 12, colour width
- XMAX, 639, largest visible x; pixels with x > XMAX are suppressed
- YMAX, 479, largest visible y; pixels with y > YMAX are suppressed
- PAT_W, 16, pattern length in pixels

Ports:
- clk  in  1  clock; one clock domain, all logic on the rising edge
- rst_  in  1  asynchronous, active-low reset
- x1_in, y1_in, x2_in, y2_in  in  COORD_W each  start point (x1,y1), end point (x2,y2)
- color  in  COLOR_W  foreground colour
- bg_color  in  COLOR_W  background colour (ALT mode only)
- mode  in  2  pattern mode: 0 SOLID, 1 DASH, 2 ALT, 3 treated as SOLID
- pattern  in  PAT_W  pattern bits, bit 0 applies to the first pixel
- in_rts  in  1  command valid
- in_rtr  out  1  ready for a command
- out_rts  out  1  pixel valid
- out_rtr  in  1  sink ready
- draw_x, draw_y  out  COORD_W each  pixel coordinate
- out_color  out  COLOR_W  pixel colour
- out_last  out  1  set on the final pixel of the line, when that pixel is emitted
- done  out  1  one-cycle pulse when the line is finished

## Operation
- **States.** IDLE → SETUP → STEP → DONE → IDLE.
- **IDLE.** in_rtr=1. On in_rts&in_rtr, latch the endpoints, colours, mode and pattern.
- **SETUP.** Computes:
  - dx=|x2−x1| and dy=|y2−y1|
  - sx and sy = ±1, the direction from the start point to the end point
  - major=max(dx,dy) and minor=min(dx,dy); x is the major axis when dx≥dy
  - err = 2·minor − major, held in a signed register COORD_W+3 bits wide
  - step counter n=0, width COORD_W+1
  - (draw_x,draw_y) = (x1,y1)
- **Traversal.** Always starts at (x1,y1) and ends at (x2,y2); there is no endpoint reordering. A line produces major+1 candidate pixels. A single point produces 1 pixel.
- **Emission of candidate n.** The pixel is *visible* when x≤XMAX, y≤YMAX, and NOT (mode=DASH and pattern[n mod PAT_W]=0).
  - Visible pixel: out_rts=1.
  - out_color = bg_color when mode=ALT and the pattern bit is 0; color otherwise.
  - out_last = (n==major).
- **Advance.** Happens on an output transfer, or in the same cycle for a suppressed pixel:
  - The major axis always steps by its sign.
  - If err≥0: the minor axis steps by its sign and err += 2·(minor−major).
  - Otherwise err += 2·minor.
  - n increments.
  - After n==major the block goes to DONE.
- **DONE.** done=1 for one cycle, then IDLE.
- **Wrap-around.** Coordinates never wrap. Clip compares use the unsigned coordinate values.

## Timing
- **Reset values.** Every output is 0 except in_rtr, which is 1 (IDLE). Reset clears all registers.
- **Reset mid-line.** Returns to IDLE immediately. No further pixels are emitted and done is not pulsed.
- **Latency.** Input transfer at cycle 0 → SETUP at cycle 1 → first candidate pixel at cycle 2.
- **Throughput.** One candidate per cycle when out_rtr=1.
- **Suppressed pixels.** Each one costs exactly one cycle with out_rts=0.
- **Handshake stability.** While out_rts=1 and out_rtr=0, draw_x, draw_y, out_color and out_last hold stable. out_rts never drops without a transfer.
- **Input gating.** in_rtr=0 from SETUP through DONE. A command arriving during DONE waits until IDLE.
- **out_last vs done.** If the final pixel is clipped or dashed, out_last is never asserted; done is always asserted.

## Structure
- Shared package `gfx_pkg`:
  - state encoding
  - mode constants MODE_SOLID, MODE_DASH, MODE_ALT
  - default XMAX and YMAX
- Natural sub-module: `line_setup`, a combinational stage that produces dx, dy, sx, sy, the major-axis select and the initial err. The top module holds the FSM, the stepping logic and the output registers.

## Test plan
- **Horizontal.** SOLID, (0,0)→(3,0), out_rtr=1 → pixels (0,0),(1,0),(2,0),(3,0). out_last only on (3,0). First out_rts at cycle 2. done at cycle 6.
- **Steep, reversed.** (2,5)→(0,0) → (2,5),(2,4),(1,3),(1,2),(0,1),(0,0).
- **Single point.** (7,7)→(7,7) → exactly one pixel, with out_last=1, then done.
- **Clipping.** (636,0)→(643,0) with defaults → x=636..639 emitted, out_last never set, done 8 step-cycles after SETUP.
- **Patterns.** PAT_W=4, pattern=4'b0101, (0,0)→(7,0):
  - DASH → x=0,2,4,6 only.
  - ALT → all 8 pixels; odd x carry bg_color.
  - Random out_rtr stalls → outputs stable while stalled.
- **Reset mid-line.** Assert rst_ low after 3 pixels of (0,0)→(9,0) → outputs go to 0 asynchronously, in_rtr=1, no done. A following command draws correctly.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline definitions: line rasteriser FSM encoding, pattern
// modes and default screen extents.
package gfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_STEP  = 2'd2,
    ST_DONE  = 2'd3
  } raster_state_t;

  // Mode 3 is unassigned and behaves like MODE_SOLID.
  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_DASH  = 2'd1;
  localparam logic [1:0] MODE_ALT   = 2'd2;

  localparam int DEF_XMAX = 639;
  localparam int DEF_YMAX = 479;

endpackage

// File: rtl/line_setup.sv
// Combinational Bresenham setup: octant, major-axis select and the initial
// decision variable together with its two per-step increments.
module line_setup #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0]        x1,
  input  logic [COORD_W-1:0]        y1,
  input  logic [COORD_W-1:0]        x2,
  input  logic [COORD_W-1:0]        y2,
  output logic [COORD_W-1:0]        major,
  output logic                      x_major,
  output logic                      sx_neg,
  output logic                      sy_neg,
  output logic signed [COORD_W+2:0] err0,
  output logic signed [COORD_W+2:0] inc_pos,
  output logic signed [COORD_W+2:0] inc_neg
);

  logic [COORD_W-1:0]        dx;
  logic [COORD_W-1:0]        dy;
  logic [COORD_W-1:0]        minor;
  logic signed [COORD_W+2:0] two_minor;
  logic signed [COORD_W+2:0] two_major;

  // NOTE: every output gets a value on every path through this block, so no
  // latch can be inferred; keep it that way when adding signals.
  always_comb begin
    sx_neg    = x2 < x1;
    sy_neg    = y2 < y1;
    dx        = sx_neg ? (x1 - x2) : (x2 - x1);
    dy        = sy_neg ? (y1 - y2) : (y2 - y1);
    x_major   = dx >= dy;
    major     = x_major ? dx : dy;
    minor     = x_major ? dy : dx;
    two_minor = $signed({2'b00, minor, 1'b0});
    two_major = $signed({2'b00, major, 1'b0});
    err0      = two_minor - $signed({3'b000, major});
    inc_pos   = two_minor - two_major;
    inc_neg   = two_minor;
  end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: one command in, one pixel per output handshake,
// with screen clipping, dash/two-colour patterns, last-pixel flag and done.
module line_raster
  import gfx_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12,
  parameter int XMAX    = DEF_XMAX,
  parameter int YMAX    = DEF_YMAX,
  parameter int PAT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [COORD_W-1:0] x1_in,
  input  logic [COORD_W-1:0] y1_in,
  input  logic [COORD_W-1:0] x2_in,
  input  logic [COORD_W-1:0] y2_in,
  input  logic [COLOR_W-1:0] color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic [1:0]         mode,
  input  logic [PAT_W-1:0]   pattern,
  input  logic               in_rts,
  output logic               in_rtr,
  output logic               out_rts,
  input  logic               out_rtr,
  output logic [COORD_W-1:0] draw_x,
  output logic [COORD_W-1:0] draw_y,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_last,
  output logic               done
);

  localparam int ERR_W = COORD_W + 3;
  localparam logic [31:0]      XMAX_U = 32'(XMAX);
  localparam logic [31:0]      YMAX_U = 32'(YMAX);
  localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
  localparam logic [COORD_W:0]   N_ONE = (COORD_W + 1)'(1);

  raster_state_t state;

  // Latched command.
  logic [COORD_W-1:0] x1_r, y1_r, x2_r, y2_r;
  logic [COLOR_W-1:0] fg_r, bg_r;
  logic [1:0]         mode_r;
  logic [PAT_W-1:0]   pat_r;     // rotated so bit 0 belongs to the current candidate

  // Stepping state.
  logic [COORD_W-1:0]     major_r;
  logic                   x_major_r, sx_neg_r, sy_neg_r;
  logic signed [ERR_W-1:0] err_r, inc_pos_r, inc_neg_r;
  logic [COORD_W:0]       n_r;

  // Setup stage outputs.
  logic [COORD_W-1:0]     su_major;
  logic                   su_x_major, su_sx_neg, su_sy_neg;
  logic signed [ERR_W-1:0] su_err0, su_inc_pos, su_inc_neg;

  // Next-candidate values.
  logic                   err_nonneg, step_x, step_y;
  logic [COORD_W-1:0]     nxt_x, nxt_y;
  logic signed [ERR_W-1:0] nxt_err;
  logic [COORD_W:0]       nxt_n;
  logic [PAT_W-1:0]       nxt_pat;
  logic                   cur_last, nxt_last, advance;

  line_setup #(.COORD_W(COORD_W)) u_setup (
    .x1      (x1_r),
    .y1      (y1_r),
    .x2      (x2_r),
    .y2      (y2_r),
    .major   (su_major),
    .x_major (su_x_major),
    .sx_neg  (su_sx_neg),
    .sy_neg  (su_sy_neg),
    .err0    (su_err0),
    .inc_pos (su_inc_pos),
    .inc_neg (su_inc_neg)
  );

  function automatic logic is_visible(input logic [COORD_W-1:0] px,
                                      input logic [COORD_W-1:0] py,
                                      input logic               pbit,
                                      input logic [1:0]         md);
    return (32'(px) <= XMAX_U) && (32'(py) <= YMAX_U) &&
           !((md == MODE_DASH) && !pbit);
  endfunction

  function automatic logic [COLOR_W-1:0] pick_color(input logic               pbit,
                                                    input logic [1:0]         md,
                                                    input logic [COLOR_W-1:0] fg,
                                                    input logic [COLOR_W-1:0] bg);
    return ((md == MODE_ALT) && !pbit) ? bg : fg;
  endfunction

  always_comb begin
    err_nonneg = ~err_r[ERR_W-1];
    step_x     = x_major_r | err_nonneg;
    step_y     = ~x_major_r | err_nonneg;
    nxt_x      = draw_x;
    nxt_y      = draw_y;
    if (step_x) nxt_x = sx_neg_r ? (draw_x - C_ONE) : (draw_x + C_ONE);
    if (step_y) nxt_y = sy_neg_r ? (draw_y - C_ONE) : (draw_y + C_ONE);
    nxt_err  = err_nonneg ? (err_r + inc_pos_r) : (err_r + inc_neg_r);
    nxt_n    = n_r + N_ONE;
    nxt_pat  = {pat_r[0], pat_r[PAT_W-1:1]};
    cur_last = (n_r == {1'b0, major_r});
    nxt_last = (nxt_n == {1'b0, major_r});
    // A suppressed candidate (out_rts low) advances without waiting for the sink.
    advance  = (state == ST_STEP) && (out_rtr || !out_rts);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= ST_IDLE;
      x1_r      <= '0;
      y1_r      <= '0;
      x2_r      <= '0;
      y2_r      <= '0;
      fg_r      <= '0;
      bg_r      <= '0;
      mode_r    <= MODE_SOLID;
      pat_r     <= '0;
      major_r   <= '0;
      x_major_r <= 1'b0;
      sx_neg_r  <= 1'b0;
      sy_neg_r  <= 1'b0;
      err_r     <= '0;
      inc_pos_r <= '0;
      inc_neg_r <= '0;
      n_r       <= '0;
      in_rtr    <= 1'b1;
      out_rts   <= 1'b0;
      draw_x    <= '0;
      draw_y    <= '0;
      out_color <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_rts && in_rtr) begin
            x1_r   <= x1_in;
            y1_r   <= y1_in;
            x2_r   <= x2_in;
            y2_r   <= y2_in;
            fg_r   <= color;
            bg_r   <= bg_color;
            mode_r <= mode;
            pat_r  <= pattern;
            in_rtr <= 1'b0;
            state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          major_r   <= su_major;
          x_major_r <= su_x_major;
          sx_neg_r  <= su_sx_neg;
          sy_neg_r  <= su_sy_neg;
          err_r     <= su_err0;
          inc_pos_r <= su_inc_pos;
          inc_neg_r <= su_inc_neg;
          n_r       <= '0;
          draw_x    <= x1_r;
          draw_y    <= y1_r;
          out_rts   <= is_visible(x1_r, y1_r, pat_r[0], mode_r);
          out_color <= pick_color(pat_r[0], mode_r, fg_r, bg_r);
          out_last  <= (su_major == '0) && is_visible(x1_r, y1_r, pat_r[0], mode_r);
          state     <= ST_STEP;
        end

        ST_STEP: begin
          if (advance) begin
            if (cur_last) begin
              out_rts  <= 1'b0;
              out_last <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              draw_x    <= nxt_x;
              draw_y    <= nxt_y;
              err_r     <= nxt_err;
              n_r       <= nxt_n;
              pat_r     <= nxt_pat;
              out_rts   <= is_visible(nxt_x, nxt_y, nxt_pat[0], mode_r);
              out_color <= pick_color(nxt_pat[0], mode_r, fg_r, bg_r);
              out_last  <= nxt_last && is_visible(nxt_x, nxt_y, nxt_pat[0], mode_r);
            end
          end
        end

        ST_DONE: begin
          in_rtr <= 1'b1;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster.sv
// Self-checking bench for line_raster: table-driven line commands with a pixel
// scoreboard, random sink stalls, random solid lines and a mid-line reset.
module tb_line_raster;

  localparam logic [11:0] FG = 12'hABC;
  localparam logic [11:0] BG = 12'h123;

  logic        clk = 1'b0;
  logic        rst_;
  logic [9:0]  x1_in, y1_in, x2_in, y2_in;
  logic [11:0] color, bg_color;
  logic [1:0]  mode;
  logic [3:0]  pattern;
  logic        in_rts, in_rtr, out_rts, out_rtr;
  logic [9:0]  draw_x, draw_y;
  logic [11:0] out_color;
  logic        out_last, done;

  line_raster #(.PAT_W(4)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .x1_in     (x1_in),
    .y1_in     (y1_in),
    .x2_in     (x2_in),
    .y2_in     (y2_in),
    .color     (color),
    .bg_color  (bg_color),
    .mode      (mode),
    .pattern   (pattern),
    .in_rts    (in_rts),
    .in_rtr    (in_rtr),
    .out_rts   (out_rts),
    .out_rtr   (out_rtr),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .out_color (out_color),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] c;
    logic        last;
  } pix_t;

  typedef struct {
    int         x1, y1, x2, y2;
    logic [1:0] mode;
    logic [3:0] pat;
    bit         stall;
    int         n;
    int         ex[8];
    int         ey[8];
    logic [7:0] bgm;
    bit         fin_last;
    int         first_lat;
    int         done_lat;
  } vec_t;

  pix_t sb[$];
  vec_t vecs[9];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int first_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int pix_cnt = 0;
  bit first_seen = 0;
  bit stall = 0;
  bit prev_stall = 0;
  logic [32:0] prev_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle numbering and command-transfer detection on the active edge.
  always @(posedge clk) begin
    if (rst_ && in_rts && in_rtr) begin
      t0 = cyc;
      first_seen = 0;
    end
    cyc++;
  end

  // Sink: random back-pressure when stall is set.
  initial begin
    out_rtr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rtr = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_) begin
      if (out_rts && !first_seen) begin
        first_seen = 1;
        first_cyc  = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall) begin
        check("stall_rts", out_rts, 1'b1);
        check("stall_hold", {draw_x, draw_y, out_color, out_last}, prev_out);
      end
      if (out_rts && out_rtr) begin
        pix_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_pixel: got (%0d,%0d) expected none (cycle %0d)", draw_x, draw_y, cyc);
        end else begin
          check("pixel", {draw_x, draw_y, out_color, out_last}, sb.pop_front());
        end
      end
      prev_stall = out_rts && !out_rtr;
      prev_out   = {draw_x, draw_y, out_color, out_last};
    end else begin
      prev_stall = 0;
    end
  end

  task automatic run_cmd(input int x1, input int y1, input int x2, input int y2,
                         input logic [1:0] md, input logic [3:0] pt, input bit stl,
                         input int first_lat, input int done_lat);
    int w;
    int d0;
    stall = stl;
    w = 0;
    @(negedge clk);
    while (!in_rtr && w < 50) begin
      @(negedge clk);
      w++;
    end
    #1;
    d0       = done_cnt;
    x1_in    = 10'(x1);
    y1_in    = 10'(y1);
    x2_in    = 10'(x2);
    y2_in    = 10'(y2);
    mode     = md;
    pattern  = pt;
    color    = FG;
    bg_color = BG;
    in_rts   = 1'b1;
    @(posedge clk);
    #1 in_rts = 1'b0;
    w = 0;
    while (done_cnt == d0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("all_pixels", sb.size(), 0);
    sb.delete();
    check("first_lat", first_cyc - t0, first_lat);
    if (done_lat >= 0) check("done_lat", done_cyc - t0, done_lat);
    check("idle_rtr", in_rtr, 1'b1);
    stall = 0;
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.n; i++)
      sb.push_back('{x: 10'(v.ex[i]), y: 10'(v.ey[i]), c: (v.bgm[i] ? BG : FG),
                     last: (i == v.n - 1) && v.fin_last});
    run_cmd(v.x1, v.y1, v.x2, v.y2, v.mode, v.pat, v.stall, v.first_lat, v.done_lat);
  endtask

  // Reference Bresenham walk for visible, solid lines.
  task automatic push_model(input int x1, input int y1, input int x2, input int y2);
    int dx, dy, sx, sy, maj, mnr, e, x, y;
    bit xm;
    dx  = (x2 >= x1) ? x2 - x1 : x1 - x2;
    dy  = (y2 >= y1) ? y2 - y1 : y1 - y2;
    sx  = (x2 >= x1) ? 1 : -1;
    sy  = (y2 >= y1) ? 1 : -1;
    xm  = dx >= dy;
    maj = xm ? dx : dy;
    mnr = xm ? dy : dx;
    e   = 2 * mnr - maj;
    x   = x1;
    y   = y1;
    for (int i = 0; i <= maj; i++) begin
      sb.push_back('{x: 10'(x), y: 10'(y), c: FG, last: (i == maj)});
      if (xm) x += sx; else y += sy;
      if (e >= 0) begin
        if (xm) y += sy; else x += sx;
        e += 2 * (mnr - maj);
      end else begin
        e += 2 * mnr;
      end
    end
  endtask

  initial begin
    int w;
    int d0;
    int base;

    vecs[0] = '{x1: 0, y1: 0, x2: 3, y2: 0, mode: 2'd0, pat: 4'hF, stall: 0, n: 4,
                ex: '{0, 1, 2, 3, 0, 0, 0, 0}, ey: '{0, 0, 0, 0, 0, 0, 0, 0},
                bgm: 8'h00, fin_last: 1, first_lat: 2, done_lat: 6};
    vecs[1] = '{x1: 2, y1: 5, x2: 0, y2: 0, mode: 2'd0, pat: 4'hF, stall: 0, n: 6,
                ex: '{2, 2, 1, 1, 0, 0, 0, 0}, ey: '{5, 4, 3, 2, 1, 0, 0, 0},
                bgm: 8'h00, fin_last: 1, first_lat: 2, done_lat: 8};
    vecs[2] = '{x1: 7, y1: 7, x2: 7, y2: 7, mode: 2'd0, pat: 4'hF, stall: 0, n: 1,
                ex: '{7, 0, 0, 0, 0, 0, 0, 0}, ey: '{7, 0, 0, 0, 0, 0, 0, 0},
                bgm: 8'h00, fin_last: 1, first_lat: 2, done_lat: 3};
    vecs[3] = '{x1: 636, y1: 0, x2: 643, y2: 0, mode: 2'd0, pat: 4'hF, stall: 0, n: 4,
                ex: '{636, 637, 638, 639, 0, 0, 0, 0}, ey: '{0, 0, 0, 0, 0, 0, 0, 0},
                bgm: 8'h00, fin_last: 0, first_lat: 2, done_lat: 10};
    vecs[4] = '{x1: 0, y1: 0, x2: 7, y2: 0, mode: 2'd1, pat: 4'b0101, stall: 0, n: 4,
                ex: '{0, 2, 4, 6, 0, 0, 0, 0}, ey: '{0, 0, 0, 0, 0, 0, 0, 0},
                bgm: 8'h00, fin_last: 0, first_lat: 2, done_lat: 10};
    vecs[5] = '{x1: 0, y1: 0, x2: 7, y2: 0, mode: 2'd2, pat: 4'b0101, stall: 0, n: 8,
                ex: '{0, 1, 2, 3, 4, 5, 6, 7}, ey: '{0, 0, 0, 0, 0, 0, 0, 0},
                bgm: 8'hAA, fin_last: 1, first_lat: 2, done_lat: 10};
    vecs[6] = '{x1: 0, y1: 0, x2: 7, y2: 0, mode: 2'd2, pat: 4'b0101, stall: 1, n: 8,
                ex: '{0, 1, 2, 3, 4, 5, 6, 7}, ey: '{0, 0, 0, 0, 0, 0, 0, 0},
                bgm: 8'hAA, fin_last: 1, first_lat: 2, done_lat: -1};
    vecs[7] = '{x1: 5, y1: 2, x2: 0, y2: 4, mode: 2'd3, pat: 4'b0000, stall: 0, n: 6,
                ex: '{5, 4, 3, 2, 1, 0, 0, 0}, ey: '{2, 2, 3, 3, 4, 4, 0, 0},
                bgm: 8'h00, fin_last: 1, first_lat: 2, done_lat: 8};
    vecs[8] = '{x1: 0, y1: 478, x2: 0, y2: 481, mode: 2'd0, pat: 4'hF, stall: 0, n: 2,
                ex: '{0, 0, 0, 0, 0, 0, 0, 0}, ey: '{478, 479, 0, 0, 0, 0, 0, 0},
                bgm: 8'h00, fin_last: 0, first_lat: 2, done_lat: 6};

    rst_     = 1'b0;
    in_rts   = 1'b0;
    x1_in    = '0;
    y1_in    = '0;
    x2_in    = '0;
    y2_in    = '0;
    color    = '0;
    bg_color = '0;
    mode     = '0;
    pattern  = '0;
    #12;
    check("reset_outputs", {out_rts, draw_x, draw_y, out_color, out_last, done}, '0);
    check("reset_in_rtr", in_rtr, 1'b1);
    @(negedge clk);
    #1 rst_ = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    for (int k = 0; k < 4; k++) begin
      int ax, ay, bx, by;
      ax = $urandom_range(0, 40);
      ay = $urandom_range(0, 40);
      bx = $urandom_range(0, 40);
      by = $urandom_range(0, 40);
      push_model(ax, ay, bx, by);
      run_cmd(ax, ay, bx, by, 2'd0, 4'hF, 1'b1, 2, -1);
    end

    // Reset in the middle of a line: outputs clear at once, no done follows.
    push_model(0, 0, 9, 0);
    base = pix_cnt;
    @(negedge clk);
    #1;
    x1_in   = 10'd0;
    y1_in   = 10'd0;
    x2_in   = 10'd9;
    y2_in   = 10'd0;
    mode    = 2'd0;
    pattern = 4'hF;
    color   = FG;
    in_rts  = 1'b1;
    @(posedge clk);
    #1 in_rts = 1'b0;
    w = 0;
    while (pix_cnt < base + 3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("pixels_before_reset", pix_cnt - base >= 3, 1'b1);
    #2 rst_ = 1'b0;
    #1;
    check("midreset_outputs", {out_rts, draw_x, draw_y, out_color, out_last, done}, '0);
    check("midreset_in_rtr", in_rtr, 1'b1);
    sb.delete();
    d0 = done_cnt;
    @(negedge clk);
    #1 rst_ = 1'b1;
    repeat (15) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    check("idle_after_reset", in_rtr, 1'b1);

    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
